mux_scan: RTL and testbench

Parametrised, registered N-channel, W-bit multiplexer. It is the sequential successor of the 8:1 single-bit combinational mux.
- **Direct mode:** selects a channel from an external select input.
- **Scan mode:** steps through all channels automatically, holding each one for a programmable number of enabled cycles.
- **Outputs:** the selected data, the channel index that produced it, a valid flag and an end-of-sweep pulse.

It sits between a bank of sampled sources and a single downstream consumer (display, serialiser, logger).

---
 rtl/mux_scan_pkg.sv | 21 ++
 rtl/mux_scan_counter.sv | 63 ++++++
 rtl/mux_scan.sv | 124 ++++++++++++
 tb/tb_mux_scan.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types for the registered scanning multiplexer: FSM states, mode
// encoding and the select/counter width helper.
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } mux_state_e;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mux_mode_e;

    // Bits needed to index v items, never less than one.
    function automatic int clog2_min1(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/mux_scan_counter.sv
// Scan position tracker: channel index plus dwell count, with a look-ahead
// flag telling the top that the current sample is the last of the sweep.
module scan_counter
    import mux_pkg::*;
#(
    parameter int  N     = 8,
    parameter int  DWELL = 4,
    localparam int SW    = clog2_min1(N),
    localparam int DW    = clog2_min1(DWELL)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [SW-1:0] idx,
    output logic          wrap_next
);

    logic [SW-1:0] idx_q;
    logic [SW-1:0] idx_d;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] dwell_d;
    logic          dwell_last_s;
    logic          idx_last_s;

    assign dwell_last_s = (dwell_q == DW'(DWELL - 1));
    assign idx_last_s   = (idx_q == SW'(N - 1));

    // Next position: clear wins, then advance on enable, otherwise hold.
    always_comb begin
        idx_d   = idx_q;
        dwell_d = dwell_q;
        if (clr) begin
            idx_d   = '0;
            dwell_d = '0;
        end else if (en) begin
            if (dwell_last_s) begin
                dwell_d = '0;
                idx_d   = idx_last_s ? '0 : (idx_q + SW'(1));
            end else begin
                dwell_d = dwell_q + DW'(1);
            end
        end else begin
            idx_d   = idx_q;
            dwell_d = dwell_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= '0;
            dwell_q <= '0;
        end else begin
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
        end
    end

    assign idx       = idx_q;
    assign wrap_next = en && !clr && dwell_last_s && idx_last_s;

endmodule

// File: rtl/mux_scan.sv
// Registered N-channel, W-bit multiplexer with a direct-select mode and an
// automatic scan mode that holds each channel for DWELL enabled cycles.
module mux_scan
    import mux_pkg::*;
#(
    parameter int  N     = 8,
    parameter int  W     = 1,
    parameter int  DWELL = 4,
    localparam int SW    = clog2_min1(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            mode,
    input  logic            en,
    input  logic [SW-1:0]   s,
    input  logic [N*W-1:0]  d,
    output logic [W-1:0]    y,
    output logic [SW-1:0]   ch,
    output logic            valid,
    output logic            sweep_end
);

    mux_state_e    state_q;
    logic [W-1:0]  y_q;
    logic [SW-1:0] ch_q;
    logic          valid_q;
    logic          sweep_end_q;

    mux_mode_e     mode_s;
    logic          scanning_s;
    logic          cnt_en_s;
    logic          cnt_clr_s;
    logic [SW-1:0] idx_s;
    logic          wrap_next_s;
    logic          s_in_range_s;
    logic [W-1:0]  s_data_s;
    logic [W-1:0]  idx_data_s;

    assign mode_s       = mux_mode_e'(mode);
    assign scanning_s   = (state_q == SCAN) && (mode_s == MODE_SCAN);
    assign cnt_en_s     = scanning_s && en;
    assign cnt_clr_s    = !scanning_s;
    assign s_in_range_s = ({1'b0, s} < (SW + 1)'(N));

    scan_counter #(
        .N     (N),
        .DWELL (DWELL)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .clr       (cnt_clr_s),
        .en        (cnt_en_s),
        .idx       (idx_s),
        .wrap_next (wrap_next_s)
    );

    // Channel pickers; an out-of-range select falls through to zero.
    always_comb begin
        s_data_s   = '0;
        idx_data_s = '0;
        for (int i = 0; i < N; i++) begin
            s_data_s   = (s == SW'(i))     ? d[i*W +: W] : s_data_s;
            idx_data_s = (idx_s == SW'(i)) ? d[i*W +: W] : idx_data_s;
        end
    end

    // Mode FSM and output registers; a mode change costs one invalid cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            y_q         <= '0;
            ch_q        <= '0;
            valid_q     <= 1'b0;
            sweep_end_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q     <= (mode_s == MODE_SCAN) ? SCAN : DIRECT;
                    y_q         <= '0;
                    ch_q        <= '0;
                    valid_q     <= 1'b0;
                    sweep_end_q <= 1'b0;
                end
                DIRECT: begin
                    if (mode_s == MODE_SCAN) begin
                        state_q     <= SCAN;
                        valid_q     <= 1'b0;
                        sweep_end_q <= 1'b0;
                    end else begin
                        y_q         <= s_in_range_s ? s_data_s : '0;
                        ch_q        <= s;
                        valid_q     <= s_in_range_s;
                        sweep_end_q <= 1'b0;
                    end
                end
                SCAN: begin
                    if (mode_s == MODE_DIRECT) begin
                        state_q     <= DIRECT;
                        valid_q     <= 1'b0;
                        sweep_end_q <= 1'b0;
                    end else begin
                        y_q         <= idx_data_s;
                        ch_q        <= idx_s;
                        valid_q     <= 1'b1;
                        sweep_end_q <= wrap_next_s;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    y_q         <= '0;
                    ch_q        <= '0;
                    valid_q     <= 1'b0;
                    sweep_end_q <= 1'b0;
                end
            endcase
        end
    end

    assign y         = y_q;
    assign ch        = ch_q;
    assign valid     = valid_q;
    assign sweep_end = sweep_end_q;

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: main instance (N=8, DWELL=2) plus N=6 range
// and DWELL=1 instances. Observations are packed {y, ch, valid, sweep_end}.
module tb_mux_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic       mode_m, en_m, mode6, en6, mode1, en1;
    logic [2:0] s_m, s6, s1;
    logic [7:0] d_m;
    logic [5:0] d6, d1;
    logic       y_m, valid_m, sweep_m, y6, valid6, sweep6, y1, valid1, sweep1;
    logic [2:0] ch_m, ch6, ch1;
    logic [5:0] obs_m, obs6, obs1, want;
    logic [5:0] d1_pattern;
    int         chk_cnt = 0;
    int         pass_cnt = 0;

    always #5 clk = ~clk;

    assign obs_m = {y_m, ch_m, valid_m, sweep_m};
    assign obs6  = {y6, ch6, valid6, sweep6};
    assign obs1  = {y1, ch1, valid1, sweep1};

    mux_scan #(.N(8), .W(1), .DWELL(2)) u_main (
        .clk(clk), .reset(reset), .mode(mode_m), .en(en_m), .s(s_m), .d(d_m),
        .y(y_m), .ch(ch_m), .valid(valid_m), .sweep_end(sweep_m));

    mux_scan #(.N(6), .W(1), .DWELL(2)) u_n6 (
        .clk(clk), .reset(reset), .mode(mode6), .en(en6), .s(s6), .d(d6),
        .y(y6), .ch(ch6), .valid(valid6), .sweep_end(sweep6));

    mux_scan #(.N(6), .W(1), .DWELL(1)) u_d1 (
        .clk(clk), .reset(reset), .mode(mode1), .en(en1), .s(s1), .d(d1),
        .y(y1), .ch(ch1), .valid(valid1), .sweep_end(sweep1));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        mode_m = 1'b0; en_m = 1'b0; s_m = 3'd3; d_m = 8'b1010_1010;
        mode6 = 1'b0; en6 = 1'b0; s6 = 3'd0; d6 = 6'b10_1010;
        mode1 = 1'b0; en1 = 1'b1; s1 = 3'd0; d1 = 6'b01_1001;
        tick; tick;
        chk_cnt++;
        if (obs_m !== 6'b0) $display("FAIL reset: got %b expected %b", obs_m, 6'b0); else pass_cnt++;
        reset = 1'b0;
        tick;
        want = {1'b0, 3'd0, 1'b0, 1'b0};
        chk_cnt++;
        if (obs_m !== want) $display("FAIL idle_cycle: got %b expected %b", obs_m, want); else pass_cnt++;
        tick;
        want = {1'b1, 3'd3, 1'b1, 1'b0};
        chk_cnt++;
        if (obs_m !== want) $display("FAIL first_direct: got %b expected %b", obs_m, want); else pass_cnt++;
    endtask

    task automatic test_direct;
        for (int i = 0; i < 8; i++) begin
            s_m = 3'(i);
            tick;
            want = {1'(i % 2), 3'(i), 1'b1, 1'b0};
            chk_cnt++;
            if (obs_m !== want) $display("FAIL direct s=%0d: got %b expected %b", i, obs_m, want); else pass_cnt++;
        end
    endtask

    task automatic test_scan;
        mode_m = 1'b1; en_m = 1'b1;
        tick;
        want = {1'b1, 3'd7, 1'b0, 1'b0};
        chk_cnt++;
        if (obs_m !== want) $display("FAIL scan_entry: got %b expected %b", obs_m, want); else pass_cnt++;
        for (int k = 0; k < 16; k++) begin
            tick;
            want = {1'((k / 2) % 2), 3'(k / 2), 1'b1, 1'(k == 15)};
            chk_cnt++;
            if (obs_m !== want) $display("FAIL scan k=%0d: got %b expected %b", k, obs_m, want); else pass_cnt++;
        end
        tick;
        want = {1'b0, 3'd0, 1'b1, 1'b0};
        chk_cnt++;
        if (obs_m !== want) $display("FAIL scan_wrap: got %b expected %b", obs_m, want); else pass_cnt++;
    endtask

    task automatic test_pause;
        for (int k = 0; k < 6; k++) tick;
        want = {1'b1, 3'd3, 1'b1, 1'b0};
        chk_cnt++;
        if (obs_m !== want) $display("FAIL pause_reach_ch3: got %b expected %b", obs_m, want); else pass_cnt++;
        en_m = 1'b0;
        for (int p = 0; p < 5; p++) begin
            if (p == 2) d_m = 8'b1010_0010;
            if (p == 3) d_m = 8'b1010_1010;
            tick;
            want = {1'(p != 2), 3'd3, 1'b1, 1'b0};
            chk_cnt++;
            if (obs_m !== want) $display("FAIL pause p=%0d: got %b expected %b", p, obs_m, want); else pass_cnt++;
        end
        en_m = 1'b1;
        tick;
        want = {1'b1, 3'd3, 1'b1, 1'b0};
        chk_cnt++;
        if (obs_m !== want) $display("FAIL resume_dwell: got %b expected %b", obs_m, want); else pass_cnt++;
        tick;
        want = {1'b0, 3'd4, 1'b1, 1'b0};
        chk_cnt++;
        if (obs_m !== want) $display("FAIL resume_next: got %b expected %b", obs_m, want); else pass_cnt++;
    endtask

    task automatic test_mode_switch;
        tick; tick;
        want = {1'b1, 3'd5, 1'b1, 1'b0};
        chk_cnt++;
        if (obs_m !== want) $display("FAIL reach_ch5: got %b expected %b", obs_m, want); else pass_cnt++;
        mode_m = 1'b0; s_m = 3'd2;
        tick;
        want = {1'b1, 3'd5, 1'b0, 1'b0};
        chk_cnt++;
        if (obs_m !== want) $display("FAIL scan_to_direct_gap: got %b expected %b", obs_m, want); else pass_cnt++;
        tick;
        want = {1'b0, 3'd2, 1'b1, 1'b0};
        chk_cnt++;
        if (obs_m !== want) $display("FAIL scan_to_direct: got %b expected %b", obs_m, want); else pass_cnt++;
        mode_m = 1'b1;
        tick;
        want = {1'b0, 3'd2, 1'b0, 1'b0};
        chk_cnt++;
        if (obs_m !== want) $display("FAIL direct_to_scan_gap: got %b expected %b", obs_m, want); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick;
            want = {1'(k == 2), 3'(k / 2), 1'b1, 1'b0};
            chk_cnt++;
            if (obs_m !== want) $display("FAIL rescan k=%0d: got %b expected %b", k, obs_m, want); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_scan;
        tick; tick; tick; tick;
        want = {1'b1, 3'd3, 1'b1, 1'b0};
        chk_cnt++;
        if (obs_m !== want) $display("FAIL pre_reset_ch3: got %b expected %b", obs_m, want); else pass_cnt++;
        reset = 1'b1;
        tick;
        chk_cnt++;
        if (obs_m !== 6'b0) $display("FAIL reset_mid_scan: got %b expected %b", obs_m, 6'b0); else pass_cnt++;
        reset = 1'b0;
        tick;
        chk_cnt++;
        if (obs_m !== 6'b0) $display("FAIL idle_to_scan_gap: got %b expected %b", obs_m, 6'b0); else pass_cnt++;
        tick;
        want = {1'b0, 3'd0, 1'b1, 1'b0};
        chk_cnt++;
        if (obs_m !== want) $display("FAIL idle_to_scan: got %b expected %b", obs_m, want); else pass_cnt++;
    endtask

    task automatic test_n6_range;
        s6 = 3'd5;
        tick;
        want = {1'b1, 3'd5, 1'b1, 1'b0};
        chk_cnt++;
        if (obs6 !== want) $display("FAIL n6_s5: got %b expected %b", obs6, want); else pass_cnt++;
        s6 = 3'd7;
        tick;
        want = {1'b0, 3'd7, 1'b0, 1'b0};
        chk_cnt++;
        if (obs6 !== want) $display("FAIL n6_s7: got %b expected %b", obs6, want); else pass_cnt++;
        s6 = 3'd6;
        tick;
        want = {1'b0, 3'd6, 1'b0, 1'b0};
        chk_cnt++;
        if (obs6 !== want) $display("FAIL n6_s6: got %b expected %b", obs6, want); else pass_cnt++;
        s6 = 3'd0;
        tick;
        want = {1'b0, 3'd0, 1'b1, 1'b0};
        chk_cnt++;
        if (obs6 !== want) $display("FAIL n6_s0: got %b expected %b", obs6, want); else pass_cnt++;
    endtask

    task automatic test_dwell1;
        d1_pattern = 6'b01_1001;
        mode1 = 1'b1; en1 = 1'b1;
        tick;
        want = {1'b1, 3'd0, 1'b0, 1'b0};
        chk_cnt++;
        if (obs1 !== want) $display("FAIL d1_entry: got %b expected %b", obs1, want); else pass_cnt++;
        for (int k = 0; k < 12; k++) begin
            tick;
            want = {d1_pattern[k % 6], 3'(k % 6), 1'b1, 1'((k % 6) == 5)};
            chk_cnt++;
            if (obs1 !== want) $display("FAIL d1 k=%0d: got %b expected %b", k, obs1, want); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset;
        test_direct;
        test_scan;
        test_pause;
        test_mode_switch;
        test_reset_mid_scan;
        test_n6_range;
        test_dwell1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
